// File: rtl/fetch_stage_if.sv
// Program-memory bus between the fetch stage and Program_Memory: the stage
// drives the fetch address and receives the combinational instruction word.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] instruction_i;

    modport master (output pc_o, input instruction_i);
    modport slave  (input pc_o, output instruction_i);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register, honours
// stall/flush/redirect and traps any capture from outside the text segment.
module fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
    parameter int                    MEMORY_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    fetch_stage_if.master         imem,
    output logic [DATA_WIDTH-1:0] if_id_instruction_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                  if_id_valid_o,
    output logic                  fault_o,
    output logic [DATA_WIDTH-1:0] fault_pc_o
);
    localparam logic [DATA_WIDTH-1:0] WINDOW = DATA_WIDTH'(4 * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] FOUR   = DATA_WIDTH'(4);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic [DATA_WIDTH-1:0] if_id_pc4_q, if_id_pc4_d;
    logic                  if_id_valid_q, if_id_valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_offset;
    logic                  pc_bad;
    logic                  capture;

    // A PC below RESET_PC wraps to a huge offset, so one unsigned compare covers both ends.
    assign pc_plus4  = pc_q + FOUR;
    assign pc_offset = pc_q - RESET_PC;
    assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_offset >= WINDOW);
    assign capture   = !flush_i && !stall_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_id_instr_q <= '0;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && capture && pc_bad) begin
            state_d = FAULT;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        if (state_q == FAULT) begin
            if_id_instr_d = '0;
            if_id_pc4_d   = '0;
            if_id_valid_d = 1'b0;
        end else if (capture && pc_bad) begin
            // Trap wins over any same-cycle redirect: the PC freezes on the bad address.
            fault_d       = 1'b1;
            fault_pc_d    = pc_q;
            if_id_instr_d = '0;
            if_id_pc4_d   = '0;
            if_id_valid_d = 1'b0;
        end else begin
            if (redirect_i) begin
                pc_d = redirect_pc_i;
            end else if (!stall_i) begin
                pc_d = pc_plus4;
            end
            if (flush_i) begin
                if_id_instr_d = '0;
                if_id_pc4_d   = '0;
                if_id_valid_d = 1'b0;
            end else if (!stall_i) begin
                if_id_instr_d = imem.instruction_i;
                if_id_pc4_d   = pc_plus4;
                if_id_valid_d = 1'b1;
            end
        end
    end

    assign imem.pc_o           = pc_q;
    assign if_id_instruction_o = if_id_instr_q;
    assign if_id_pc_plus4_o    = if_id_pc4_q;
    assign if_id_valid_o       = if_id_valid_q;
    assign fault_o             = fault_q;
    assign fault_pc_o          = fault_pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed test-plan walk followed by random stall/flush/redirect traffic,
// every edge compared against a rule-level model of the fetch stage.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          DEPTH    = 256;

    logic        clk = 1'b0;
    logic        reset, stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] if_id_instruction_o, if_id_pc_plus4_o, fault_pc_o;
    logic        if_id_valid_o, fault_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_instr, m_pc4, m_fpc;
    logic        m_valid, m_fault;
    logic [31:0] prog_mem [DEPTH];

    fetch_stage_if #(.DATA_WIDTH(32)) imem ();

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RESET_PC), .MEMORY_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_i             (stall_i),
        .flush_i             (flush_i),
        .redirect_i          (redirect_i),
        .redirect_pc_i       (redirect_pc_i),
        .imem                (imem.master),
        .if_id_instruction_o (if_id_instruction_o),
        .if_id_pc_plus4_o    (if_id_pc_plus4_o),
        .if_id_valid_o       (if_id_valid_o),
        .fault_o             (fault_o),
        .fault_pc_o          (fault_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic in_text(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a - RESET_PC) < 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        logic [31:0] off;
        off = (a - RESET_PC) >> 2;
        if (in_text(a)) return prog_mem[off[7:0]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb imem.instruction_i = fetch_word(imem.pc_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected behaviour of one rising edge, taken straight from the stage's rules.
    task automatic model_edge(input logic r, input logic st, input logic fl,
                              input logic rd, input logic [31:0] tgt);
        logic [31:0] seq;
        if (r) begin
            m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0; m_fpc = 0;
        end else if (m_fault) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (!st && !fl && !in_text(m_pc)) begin
            m_fault = 1; m_fpc = m_pc; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            seq = m_pc + 32'd4;
            if (fl) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!st) begin
                m_instr = fetch_word(m_pc); m_pc4 = seq; m_valid = 1;
            end
            m_pc = rd ? tgt : (st ? m_pc : seq);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic fl,
                        input logic rd, input logic [31:0] tgt);
        reset = r; stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = tgt;
        model_edge(r, st, fl, rd, tgt);
        @(posedge clk);
        #1;
        check("pc", imem.pc_o, m_pc);
        check("instr", if_id_instruction_o, m_instr);
        check("pc4", if_id_pc_plus4_o, m_pc4);
        check("valid", {31'd0, if_id_valid_o}, {31'd0, m_valid});
        check("fault", {31'd0, fault_o}, {31'd0, m_fault});
        check("fault_pc", fault_pc_o, m_fpc);
        $display("t=%0t rst=%0b st=%0b fl=%0b rd=%0b tgt=%h pc=%h ifid=%h/%h/%0b flt=%0b/%h",
                 $time, r, st, fl, rd, tgt, imem.pc_o, if_id_instruction_o,
                 if_id_pc_plus4_o, if_id_valid_o, fault_o, fault_pc_o);
    endtask

    initial begin
        logic [31:0] tgt;
        int          sel;
        for (int i = 0; i < DEPTH; i++) prog_mem[i] = 32'h1000_0000 + 32'(i);
        reset = 1; stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 0;
        #1;

        // Reset and sequential fetch
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_pc", imem.pc_o, 32'h0040_0000);
        check("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
        step(0, 0, 0, 0, 0);
        check("seq1_pc", imem.pc_o, 32'h0040_0004);
        check("seq1_instr", if_id_instruction_o, 32'h1000_0000);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("stall_pc", imem.pc_o, 32'h0040_0008);
        check("stall_instr", if_id_instruction_o, 32'h1000_0001);
        step(0, 0, 0, 0, 0);
        check("unstall_instr", if_id_instruction_o, 32'h1000_0002);

        // Redirect with flush, then redirect with stall
        step(0, 0, 1, 1, 32'h0040_0040);
        check("redir_pc", imem.pc_o, 32'h0040_0040);
        step(0, 0, 0, 0, 0);
        check("redir_instr", if_id_instruction_o, 32'h1000_0010);
        check("redir_pc4", if_id_pc_plus4_o, 32'h0040_0044);
        step(0, 1, 0, 1, 32'h0040_0080);
        check("redir_stall_instr", if_id_instruction_o, 32'h1000_0010);

        // Misaligned redirect target
        step(0, 0, 0, 1, 32'h0040_0002);
        step(0, 0, 0, 0, 0);
        check("mis_fault_pc", fault_pc_o, 32'h0040_0002);
        step(0, 1, 0, 1, 32'h0040_0100);
        step(0, 0, 1, 0, 0);
        check("mis_frozen_pc", imem.pc_o, 32'h0040_0002);
        step(1, 0, 0, 0, 0);

        // Sequencing past the end of the text segment
        step(0, 0, 1, 1, 32'h0040_03FC);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("end_fault_pc", fault_pc_o, 32'h0040_0400);
        step(1, 0, 0, 0, 0);

        // Below the text segment; reset during FAULT and during stall
        step(0, 0, 0, 1, 32'h003F_FFFC);
        step(0, 0, 0, 1, 32'h0040_0000);
        check("low_fault_pc", fault_pc_o, 32'h003F_FFFC);
        step(1, 1, 1, 1, 32'h0040_0020);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 1, 1, 32'h0040_0020);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) tgt = RESET_PC + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'd2;
            else if (sel == 1) tgt = 32'h003F_FFFC;
            else if (sel == 2) tgt = RESET_PC + 32'(4 * (DEPTH - 1));
            else tgt = RESET_PC + 32'(4 * $urandom_range(0, DEPTH - 1));
            step(m_fault && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
